// File: rtl/serial_sub_ctrl.sv
// Bit-serial two's-complement subtractor: one full-subtractor cell stepped LSB first over WIDTH cycles.
// Define SUB_OVF_EN to add the signed-overflow output ovf.
module serial_sub_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
`ifdef SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_reg;
    logic [WIDTH-1:0] sa_reg;
    logic [WIDTH-1:0] sb_reg;
    logic [WIDTH-1:0] sd_reg;
    logic [CW-1:0]    cnt_reg;
    logic             bin_reg;

    logic             d_bit;
    logic             bout_bit;
    logic [WIDTH-1:0] sd_next;

    always_comb begin
        d_bit    = sa_reg[0] ^ sb_reg[0] ^ bin_reg;
        bout_bit = (~sa_reg[0] & sb_reg[0]) | (~(sa_reg[0] ^ sb_reg[0]) & bin_reg);
        sd_next  = {d_bit, sd_reg[WIDTH-1:1]};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            sa_reg    <= '0;
            sb_reg    <= '0;
            sd_reg    <= '0;
            cnt_reg   <= '0;
            bin_reg   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            diff      <= '0;
            borrow    <= 1'b0;
`ifdef SUB_OVF_EN
            ovf       <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        sa_reg    <= a;
                        sb_reg    <= b;
                        sd_reg    <= '0;
                        cnt_reg   <= '0;
                        bin_reg   <= 1'b0;
                        busy      <= 1'b1;
                        state_reg <= RUN;
                    end
                end
                RUN: begin
                    sd_reg  <= sd_next;
                    sa_reg  <= sa_reg >> 1;
                    sb_reg  <= sb_reg >> 1;
                    bin_reg <= bout_bit;
                    // Counter is held on the MSB edge so it never wraps within an operation.
                    if (cnt_reg == LAST_BIT) begin
                        state_reg <= DONE;
                        done      <= 1'b1;
                        diff      <= sd_next;
                        borrow    <= bout_bit;
`ifdef SUB_OVF_EN
                        ovf       <= bin_reg ^ bout_bit;
`endif
                    end else begin
                        cnt_reg <= cnt_reg + CW'(1);
                    end
                end
                DONE: begin
                    busy      <= 1'b0;
                    state_reg <= IDLE;
                end
                default: begin
                    busy      <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Self-checking bench for serial_sub_ctrl (WIDTH = 8): vector table, corner sequences, random ops vs. arithmetic model.
module tb_serial_sub_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       busy;
    logic       done;
    logic [7:0] diff;
    logic       borrow;
`ifdef SUB_OVF_EN
    logic       ovf;
`endif

    int tests = 0;
    int fails = 0;

    serial_sub_ctrl #(.WIDTH(8)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .diff   (diff),
        .borrow (borrow)
`ifdef SUB_OVF_EN
        ,
        .ovf    (ovf)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] va;
        logic [7:0] vb;
        logic [7:0] exp_diff;
        logic       exp_borrow;
        logic       exp_ovf;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One start pulse from IDLE, then track timing, stability and result against the given expectation.
    task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_v, input logic [7:0] ed,
                          input logic eb, input logic eo, input string name);
        int         lat;
        bit         stable;
        bit         busy_ok;
        logic [7:0] pd;
        logic       pb;
        @(negedge clk);
        a = ta; b = tb_v; start = 1'b1;
        pd = diff; pb = borrow;
        @(negedge clk);
        start = 1'b0; a = 8'($urandom); b = 8'($urandom);
        lat = 0; stable = 1'b1; busy_ok = 1'b1;
        while (!done && lat < 20) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            if (diff !== pd || borrow !== pb) stable = 1'b0;
            @(negedge clk);
            lat++;
        end
        check({name, " latency"}, 32'(lat), 32'd8);
        check({name, " busy_run"}, {31'd0, busy_ok}, 32'd1);
        check({name, " hold"}, {31'd0, stable}, 32'd1);
        check({name, " diff"}, {24'd0, diff}, {24'd0, ed});
        check({name, " borrow"}, {31'd0, borrow}, {31'd0, eb});
`ifdef SUB_OVF_EN
        check({name, " ovf"}, {31'd0, ovf}, {31'd0, eo});
`else
        if (eo === 1'bx) $display("[TB] unexpected ovf x");
`endif
        @(negedge clk);
        check({name, " done_pulse_busy_fall"}, {30'd0, done, busy}, 32'd0);
        $display("[TB] %s: a=%02h b=%02h -> diff=%02h borrow=%0b latency=%0d", name, ta, tb_v, diff, borrow, lat);
    endtask

    function automatic logic model_ovf(input logic [7:0] ma, input logic [7:0] mb);
        int r;
        r = int'($signed(ma)) - int'($signed(mb));
        return (r > 127 || r < -128);
    endfunction

    initial begin
        vec_t vecs[10];
        int   cyc;
        int   dcount;
        int   t_done[3];
        int   nd;

        vecs[0] = '{8'h07, 8'h05, 8'h02, 1'b0, 1'b0};
        vecs[1] = '{8'h05, 8'h07, 8'hFE, 1'b1, 1'b0};
        vecs[2] = '{8'h00, 8'h01, 8'hFF, 1'b1, 1'b0};
        vecs[3] = '{8'h80, 8'h01, 8'h7F, 1'b0, 1'b1};
        vecs[4] = '{8'h57, 8'h57, 8'h00, 1'b0, 1'b0};
        vecs[5] = '{8'h10, 8'h01, 8'h0F, 1'b0, 1'b0};
        vecs[6] = '{8'hFF, 8'h00, 8'hFF, 1'b0, 1'b0};
        vecs[7] = '{8'h00, 8'hFF, 8'h01, 1'b1, 1'b0};
        vecs[8] = '{8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1};
        vecs[9] = '{8'h80, 8'h7F, 8'h01, 1'b0, 1'b1};

        reset = 1'b1; start = 1'b1; a = 8'hAA; b = 8'h11;
        repeat (3) @(negedge clk);
        check("reset busy/done", {30'd0, busy, done}, 32'd0);
        check("reset diff", {24'd0, diff}, 32'd0);
        check("reset borrow", {31'd0, borrow}, 32'd0);
`ifdef SUB_OVF_EN
        check("reset ovf", {31'd0, ovf}, 32'd0);
`endif
        start = 1'b0; reset = 1'b0;
        @(negedge clk);
        check("idle after reset", {31'd0, busy}, 32'd0);

        for (int i = 0; i < 10; i++)
            run_op(vecs[i].va, vecs[i].vb, vecs[i].exp_diff, vecs[i].exp_borrow, vecs[i].exp_ovf,
                   $sformatf("vec%0d", i));

        // Start pulses in RUN and DONE must be ignored.
        @(negedge clk);
        a = 8'h10; b = 8'h01; start = 1'b1;
        @(negedge clk);
        start = 1'b0; a = 8'h33; b = 8'h22;
        repeat (3) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (!done && cyc < 20) begin @(negedge clk); cyc++; end
        dcount = done ? 1 : 0;
        start = 1'b1; a = 8'h44; b = 8'h01;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done) dcount++;
        end
        check("busy_start done_count", 32'(dcount), 32'd1);
        check("busy_start diff", {24'd0, diff}, 32'h0F);
        $display("[TB] start-while-busy: done_count=%0d diff=%02h", dcount, diff);

        // Held start: back-to-back accepts every WIDTH+2 cycles.
        @(negedge clk);
        a = 8'h20; b = 8'h03; start = 1'b1;
        nd = 0;
        for (int c = 0; c < 60 && nd < 3; c++) begin
            @(negedge clk);
            if (done) begin t_done[nd] = c; nd++; end
        end
        start = 1'b0;
        check("held_start pulses", 32'(nd), 32'd3);
        if (nd == 3) begin
            check("held_start gap1", 32'(t_done[1] - t_done[0]), 32'd10);
            check("held_start gap2", 32'(t_done[2] - t_done[1]), 32'd10);
        end
        check("held_start diff", {24'd0, diff}, 32'h1D);
        $display("[TB] held start: %0d done pulses", nd);
        repeat (12) @(negedge clk);

        // Reset on the 4th RUN edge discards the operation.
        a = 8'h40; b = 8'h05; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midreset busy/done", {30'd0, busy, done}, 32'd0);
        check("midreset diff/borrow", {23'd0, diff, borrow}, 32'd0);
        dcount = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done || busy) dcount++;
        end
        check("midreset no_done", 32'(dcount), 32'd0);
        $display("[TB] reset mid-run: busy=%0b diff=%02h", busy, diff);
        run_op(8'h09, 8'h03, 8'h06, 1'b0, 1'b0, "after_reset");

        for (int i = 0; i < 40; i++) begin
            logic [7:0] ra, rb;
            ra = 8'($urandom_range(0, 255));
            rb = (i % 8 == 0) ? ra : 8'($urandom_range(0, 255));
            run_op(ra, rb, 8'(int'(ra) - int'(rb)), (ra < rb), model_ovf(ra, rb),
                   $sformatf("rand%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
